// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC sequencer: reset hold-off, sequential/redirected fetch, stall and halt handling.
// Optional build macro PC_ALIGN_CHECK_EN traps misaligned redirect targets instead of truncating them.
module pc_fetch_ctrl #(
  parameter int unsigned RESET_HOLD = 2
) (
  input  logic        run,
  input  logic        reset,
  input  logic [31:0] initialPCval,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        halted,
  output logic [31:0] instr_count,
  output logic        fault
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HOLD_W = 4;
  localparam logic [XLEN-1:0] HALT_INSTR = 32'h0000_000D;

  typedef enum logic [1:0] {
    S_HOLD,
    S_FETCH,
    S_STALL,
    S_HALT
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              redirect;
  logic [XLEN-1:0]   target;

  // Jump outranks branch when both are raised.
  always_comb begin
    redirect = jump | branch_taken;
    target   = jump ? jump_target : branch_target;
  end

  assign pc_plus4    = pc + XLEN'(4);
  assign fetch_valid = (state == S_FETCH) && !stall;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = redirect && (target[1:0] != 2'b00);
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge run) begin
    if (reset) begin
      state       <= S_HOLD;
      hold_cnt    <= HOLD_W'(RESET_HOLD);
      pc          <= initialPCval;
      instr_count <= '0;
      halted      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      fault       <= 1'b0;
`endif
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt <= HOLD_W'(1)) state <= S_FETCH;
          else                        hold_cnt <= hold_cnt - HOLD_W'(1);
        end
        S_FETCH: begin
          if (stall) begin
            state <= S_STALL;
          end else begin
            instr_count <= instr_count + XLEN'(1);
            // A break wins over any redirect raised in the same cycle.
            if (instr == HALT_INSTR) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
              if (misaligned) begin
                fault  <= 1'b1;
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                pc <= target;
              end
`else
              pc <= target & ~XLEN'(3);
`endif
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        S_STALL: begin
          if (!stall) state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: vector table, directed corner sequences and random stimulus vs a reference model.
module tb_pc_fetch_ctrl;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int HOLD = 2;

  logic        run = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] initialPCval = '0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] instr = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic [31:0] instr_count;
  logic        fault;

  pc_fetch_ctrl #(.RESET_HOLD(HOLD)) dut (
    .run(run), .reset(reset), .initialPCval(initialPCval), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instr(instr),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .halted(halted), .instr_count(instr_count), .fault(fault)
  );

  always #5 run = ~run;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passed++;
  endtask

  // Reference model: remaining hold cycles, stall/halt flags, plain arithmetic on pc.
  bit          m_known = 0;
  int          m_hold;
  bit          m_stalled, m_halt, m_fault;
  logic [31:0] m_pc, m_cnt;

  task automatic model_edge();
    longint t;
    if (reset) begin
      m_known = 1; m_hold = HOLD; m_stalled = 0; m_halt = 0; m_fault = 0;
      m_pc = initialPCval; m_cnt = 0;
    end else if (!m_known || m_halt) begin
      // nothing moves
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (m_stalled) begin
      if (!stall) m_stalled = 0;
    end else if (stall) begin
      m_stalled = 1;
    end else begin
      m_cnt = m_cnt + 1;
      if (instr == 32'd13) m_halt = 1;
      else if (jump || branch_taken) begin
        t = jump ? longint'(jump_target) : longint'(branch_target);
        if (ALIGN && (t % 4) != 0) begin
          m_fault = 1; m_halt = 1;
        end else begin
          m_pc = 32'(t - (t % 4));
        end
      end else begin
        m_pc = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000);
      end
    end
  endtask

  // Compare against the model, then advance one clock.
  task automatic step();
    #1;
    if (m_known) begin
      chk("m_pc", pc, m_pc);
      chk("m_pc_plus4", pc_plus4, 32'((longint'(m_pc) + 4) % 64'h1_0000_0000));
      chk("m_fetch_valid", 32'(fetch_valid), 32'(!m_halt && m_hold == 0 && !m_stalled && !stall));
      chk("m_halted", 32'(halted), 32'(m_halt));
      chk("m_instr_count", instr_count, m_cnt);
      chk("m_fault", 32'(fault), 32'(m_fault));
    end
    @(posedge run);
    model_edge();
    @(negedge run);
  endtask

  task automatic clear_inputs();
    reset = 0; stall = 0; jump = 0; branch_taken = 0; instr = 0;
    jump_target = 0; branch_target = 0;
  endtask

  // Reset for one cycle, then sit out the hold window so the next cycle is a fetch.
  task automatic do_reset(input logic [31:0] init);
    clear_inputs();
    initialPCval = init;
    reset = 1; step();
    reset = 0;
    repeat (HOLD) step();
  endtask

  typedef struct {
    bit rst, stl, jmp, br;
    logic [31:0] jt, bt, ins;
    bit chk;
    logic [31:0] e_pc;
    bit e_fv;
    logic [31:0] e_cnt;
    bit e_halt;
  } vec_t;

  function automatic vec_t mk(bit rst, bit stl, bit jmp, bit br, logic [31:0] jt, logic [31:0] bt,
                              logic [31:0] ins, bit c, logic [31:0] p, bit fv, logic [31:0] cnt, bit h);
    vec_t v;
    v.rst = rst; v.stl = stl; v.jmp = jmp; v.br = br; v.jt = jt; v.bt = bt; v.ins = ins;
    v.chk = c; v.e_pc = p; v.e_fv = fv; v.e_cnt = cnt; v.e_halt = h;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(1,0,0,0, 0,     0,     0,  0, 0,          0, 0, 0);
    tbl[1]  = mk(0,0,0,0, 0,     0,     0,  1, 32'h400000, 0, 0, 0);
    tbl[2]  = mk(0,0,0,0, 0,     0,     0,  1, 32'h400000, 0, 0, 0);
    tbl[3]  = mk(0,0,0,0, 0,     0,     0,  1, 32'h400000, 1, 0, 0);
    tbl[4]  = mk(0,0,0,0, 0,     0,     0,  1, 32'h400004, 1, 1, 0);
    tbl[5]  = mk(0,0,1,1, 'h200, 'h300, 0,  1, 32'h400008, 1, 2, 0);
    tbl[6]  = mk(0,0,0,1, 0,     'h300, 0,  1, 32'h200,    1, 3, 0);
    tbl[7]  = mk(0,1,0,0, 0,     0,     0,  1, 32'h300,    0, 4, 0);
    tbl[8]  = mk(0,1,1,0, 'h500, 0,     0,  1, 32'h300,    0, 4, 0);
    tbl[9]  = mk(0,1,0,0, 0,     0,     0,  1, 32'h300,    0, 4, 0);
    tbl[10] = mk(0,0,0,0, 0,     0,     0,  1, 32'h300,    0, 4, 0);
    tbl[11] = mk(0,0,0,0, 0,     0,     13, 1, 32'h300,    1, 4, 0);
    tbl[12] = mk(0,0,0,0, 0,     0,     0,  1, 32'h300,    0, 5, 1);
    tbl[13] = mk(0,0,1,0, 'h600, 0,     0,  1, 32'h300,    0, 5, 1);
    tbl[14] = mk(1,0,0,0, 0,     0,     0,  1, 32'h300,    0, 5, 1);
    tbl[15] = mk(0,0,0,0, 0,     0,     0,  1, 32'h400000, 0, 0, 0);

    @(negedge run);
    initialPCval = 32'h0040_0000;
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst; stall = tbl[i].stl; jump = tbl[i].jmp; branch_taken = tbl[i].br;
      jump_target = tbl[i].jt; branch_target = tbl[i].bt; instr = tbl[i].ins;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_fv", i), 32'(fetch_valid), 32'(tbl[i].e_fv));
        chk($sformatf("tbl%0d_cnt", i), instr_count, tbl[i].e_cnt);
        chk($sformatf("tbl%0d_halt", i), 32'(halted), 32'(tbl[i].e_halt));
      end
      step();
    end

    // Sequential pc wraps past the top of the address space.
    do_reset(32'hFFFF_FFFC);
    #1; chk("wrap_first_pc", pc, 32'hFFFF_FFFC);
    step();
    #1; chk("wrap_second_pc", pc, 32'h0);
    chk("wrap_second_fv", 32'(fetch_valid), 32'd1);

    // Misaligned jump target: trap or truncate depending on build.
    do_reset(32'h100);
    jump = 1; jump_target = 32'h202;
    step();
    clear_inputs();
    #1;
    chk("misalign_pc", pc, ALIGN ? 32'h100 : 32'h200);
    chk("misalign_fault", 32'(fault), 32'(ALIGN));
    chk("misalign_halted", 32'(halted), 32'(ALIGN));

    // Three-cycle stall at 0x104 holds pc and count.
    do_reset(32'h100);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_pc", i), pc, 32'h104);
      chk($sformatf("stall%0d_fv", i), 32'(fetch_valid), 32'd0);
      chk($sformatf("stall%0d_cnt", i), instr_count, 32'd1);
      step();
    end
    stall = 0;
    #1; chk("unstall_bubble_fv", 32'(fetch_valid), 32'd0);
    step();
    #1; chk("unstall_fetch_pc", pc, 32'h104);
    chk("unstall_fetch_fv", 32'(fetch_valid), 32'd1);
    step();
    #1; chk("after_stall_pc", pc, 32'h108);
    chk("after_stall_cnt", instr_count, 32'd2);

    // Break at 0x10C is sticky against any input, then reset recovers.
    do_reset(32'h10C);
    instr = 32'h0000_000D;
    step();
    for (int i = 0; i < 10; i++) begin
      jump = 1'($urandom); branch_taken = 1'($urandom); stall = 1'($urandom);
      jump_target = $urandom; branch_target = $urandom; instr = $urandom;
      #1;
      chk($sformatf("halt%0d_pc", i), pc, 32'h10C);
      chk($sformatf("halt%0d_halted", i), 32'(halted), 32'd1);
      chk($sformatf("halt%0d_cnt", i), instr_count, 32'd1);
      step();
    end
    clear_inputs();
    initialPCval = 32'h40;
    reset = 1; step();
    reset = 0;
    #1; chk("halt_reset_pc", pc, 32'h40);
    chk("halt_reset_halted", 32'(halted), 32'd0);
    chk("halt_reset_fv", 32'(fetch_valid), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(63) == 0);
      stall = ($urandom_range(3) == 0);
      jump = ($urandom_range(7) == 0);
      branch_taken = ($urandom_range(7) == 0);
      jump_target = $urandom;
      branch_target = $urandom;
      if ($urandom_range(1) == 0) begin
        jump_target[1:0] = 2'b00;
        branch_target[1:0] = 2'b00;
      end
      instr = ($urandom_range(39) == 0) ? 32'h0000_000D : $urandom;
      initialPCval = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
